// File: rtl/pe_array_obf_collector_if.sv
// OBF write port: one row result per valid/ready beat, from the row collector
// (master) to the OBF SRAM write controller (slave).
interface pe_array_obf_collector_if #(
  parameter int addr_width   = 10,
  parameter int output_width = 24
);
  logic                    obf_wr_valid;
  logic                    obf_wr_ready;
  logic [addr_width-1:0]   obf_wr_addr;
  logic [output_width-1:0] obf_wr_data;

  modport master (
    output obf_wr_valid,
    output obf_wr_addr,
    output obf_wr_data,
    input  obf_wr_ready
  );

  modport slave (
    input  obf_wr_valid,
    input  obf_wr_addr,
    input  obf_wr_data,
    output obf_wr_ready
  );
endinterface

// File: rtl/pe_array_obf_collector.sv
// Double-buffered capture of PE-array row results, drained one row per beat into the OBF.
// Optional build macro OBF_RELU_EN clamps negative row values to zero at capture time.
module pe_array_obf_collector #(
  parameter int nb_pe_row    = 8,
  parameter int output_width = 24,
  parameter int OBF_depth    = 1024,
  parameter int addr_width   = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [nb_pe_row*output_width-1:0] out_to_OBF_all_rows,
  input  logic                              capture_en,
  input  logic                              clr,
  pe_array_obf_collector_if.master          obf,
  output logic                              collector_full,
  output logic                              overflow
);

  localparam int idx_width = (nb_pe_row > 1) ? $clog2(nb_pe_row) : 1;
  localparam logic [idx_width-1:0]  last_row  = idx_width'(nb_pe_row - 1);
  localparam logic [addr_width-1:0] last_addr = addr_width'(OBF_depth - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                          state;
  state_t                          next_state;
  logic [output_width-1:0]         bank_mem [2][nb_pe_row];
  logic [1:0]                      bank_full;
  logic                            wr_bank;
  logic                            rd_bank;
  logic [idx_width-1:0]            row_idx;
  logic [addr_width-1:0]           wr_addr;
  logic                            beat;
  logic                            last_beat;
  logic                            capture_ok;
  logic [nb_pe_row*output_width-1:0] rows_in;

  always_comb begin
    rows_in = out_to_OBF_all_rows;
`ifdef OBF_RELU_EN
    for (int r = 0; r < nb_pe_row; r++) begin
      if (out_to_OBF_all_rows[(r+1)*output_width-1]) begin
        rows_in[r*output_width +: output_width] = '0;
      end
    end
`endif
  end

  assign beat      = (state == SEND) && obf.obf_wr_ready;
  assign last_beat = beat && (row_idx == last_row);

  // A full write bank is still usable when its final beat leaves in this same cycle.
  assign capture_ok = capture_en &&
                      (!bank_full[wr_bank] || (last_beat && (rd_bank == wr_bank)));

  always_ff @(posedge clk) begin
    if (capture_ok && !clr) begin
      for (int r = 0; r < nb_pe_row; r++) begin
        bank_mem[wr_bank][r] <= rows_in[r*output_width +: output_width];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (clr) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bank_full[rd_bank]) next_state = SEND;
      SEND:    if (last_beat) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx <= '0;
    end else if (clr || (state == IDLE) || last_beat) begin
      row_idx <= '0;
    end else if (beat) begin
      row_idx <= row_idx + 1'b1;
    end
  end

  // Capture setting a bank's flag wins over the drain clearing it, so a same-cycle
  // refill of the bank being emptied leaves it full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_addr   <= '0;
      overflow  <= 1'b0;
    end else if (clr) begin
      bank_full <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_addr   <= '0;
      overflow  <= 1'b0;
    end else begin
      if (capture_ok) wr_bank <= ~wr_bank;
      if (last_beat)  rd_bank <= ~rd_bank;
      if (beat) begin
        wr_addr <= (wr_addr == last_addr) ? '0 : wr_addr + 1'b1;
      end
      for (int b = 0; b < 2; b++) begin
        if (capture_ok && (wr_bank == 1'(b))) begin
          bank_full[b] <= 1'b1;
        end else if (last_beat && (rd_bank == 1'(b))) begin
          bank_full[b] <= 1'b0;
        end
      end
      if (capture_en && !capture_ok) overflow <= 1'b1;
    end
  end

  assign obf.obf_wr_valid = (state == SEND);
  assign obf.obf_wr_addr  = wr_addr;
  assign obf.obf_wr_data  = (state == SEND) ? bank_mem[rd_bank][row_idx] : '0;
  assign collector_full   = &bank_full;

endmodule

// File: tb/tb_pe_array_obf_collector.sv
// Directed, table-driven bench for pe_array_obf_collector; honours OBF_RELU_EN like the design.
module tb_pe_array_obf_collector;

  localparam int nb_pe_row    = 8;
  localparam int output_width = 24;
  localparam int OBF_depth    = 1024;
  localparam int addr_width   = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic capture_en = 1'b0;
  logic clr = 1'b0;
  logic [nb_pe_row*output_width-1:0] rows_bus = '0;
  logic collector_full;
  logic overflow;

  int checks = 0;
  int failures = 0;

  pe_array_obf_collector_if #(.addr_width(addr_width), .output_width(output_width)) obf ();

  pe_array_obf_collector #(
    .nb_pe_row(nb_pe_row), .output_width(output_width),
    .OBF_depth(OBF_depth), .addr_width(addr_width)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .out_to_OBF_all_rows(rows_bus),
    .capture_en(capture_en),
    .clr(clr),
    .obf(obf.master),
    .collector_full(collector_full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                    cap;
    logic                    rdy;
    logic                    clr;
    logic                    e_valid;
    logic [addr_width-1:0]   e_addr;
    logic [output_width-1:0] e_data;
    logic                    e_full;
    logic                    e_ovf;
  } vec_t;

  vec_t t1 [12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are driven at a falling edge and held for one rising edge; capture/clr are one-shot.
  task automatic applyStimulus(input logic cap, input logic rdy, input logic clear);
    capture_en       = cap;
    obf.obf_wr_ready = rdy;
    clr              = clear;
    @(negedge clk);
    capture_en = 1'b0;
    clr        = 1'b0;
  endtask

  task automatic setRows(input logic [output_width-1:0] base);
    for (int r = 0; r < nb_pe_row; r++) begin
      rows_bus[r*output_width +: output_width] = base + output_width'(r);
    end
  endtask

  // Beat j carries row j%8 of snapshot base_a (j<8) or base_b, at address start+j modulo depth.
  task automatic drainCheck(input string tag, input int nbeats, input int start_addr,
                            input logic [output_width-1:0] base_a,
                            input logic [output_width-1:0] base_b, input bit toggle);
    int j;
    int cyc;
    logic [output_width-1:0] base;
    j = 0;
    cyc = 0;
    while (j < nbeats && cyc < 400) begin
      obf.obf_wr_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (obf.obf_wr_valid) begin
        base = (j < nb_pe_row) ? base_a : base_b;
        checkOutput({tag, "_addr"}, 32'(obf.obf_wr_addr), 32'((start_addr + j) % OBF_depth));
        checkOutput({tag, "_data"}, 32'(obf.obf_wr_data), 32'(base + output_width'(j % nb_pe_row)));
        if (obf.obf_wr_ready) j++;
      end else if ((j % nb_pe_row) != 0) begin
        checkOutput({tag, "_valid_hold"}, 32'(obf.obf_wr_valid), 32'd1);
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_beats"}, 32'(j), 32'(nbeats));
    obf.obf_wr_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [output_width-1:0] relu_exp;

    obf.obf_wr_ready = 1'b0;
    t1[0] = '{1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0};
    t1[1] = '{1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0};
    for (int i = 2; i < 10; i++) begin
      t1[i] = '{1'b0, 1'b1, 1'b0, 1'b1, addr_width'(i - 2), output_width'(i - 1), 1'b0, 1'b0};
    end
    t1[10] = '{1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0};
    t1[11] = '{1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", 32'(obf.obf_wr_valid), 32'd0);
    checkOutput("rst_addr", 32'(obf.obf_wr_addr), 32'd0);
    checkOutput("rst_data", 32'(obf.obf_wr_data), 32'd0);
    checkOutput("rst_full", 32'(collector_full), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single snapshot, rows 1..8, ready held high
    setRows(24'd1);
    for (int i = 0; i < 12; i++) begin
      checkOutput($sformatf("t1_valid[%0d]", i), 32'(obf.obf_wr_valid), 32'(t1[i].e_valid));
      if (t1[i].e_valid) begin
        checkOutput($sformatf("t1_addr[%0d]", i), 32'(obf.obf_wr_addr), 32'(t1[i].e_addr));
        checkOutput($sformatf("t1_data[%0d]", i), 32'(obf.obf_wr_data), 32'(t1[i].e_data));
      end
      checkOutput($sformatf("t1_full[%0d]", i), 32'(collector_full), 32'(t1[i].e_full));
      checkOutput($sformatf("t1_ovf[%0d]", i), 32'(overflow), 32'(t1[i].e_ovf));
      applyStimulus(t1[i].cap, t1[i].rdy, t1[i].clr);
    end

    // Three back-to-back captures with ready low: third one dropped
    setRows(24'h100);
    applyStimulus(1'b1, 1'b0, 1'b0);
    setRows(24'h200);
    applyStimulus(1'b1, 1'b0, 1'b0);
    setRows(24'h300);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t2_full", 32'(collector_full), 32'd1);
    checkOutput("t2_ovf", 32'(overflow), 32'd1);
    checkOutput("t2_valid", 32'(obf.obf_wr_valid), 32'd1);
    drainCheck("t2", 16, 8, 24'h100, 24'h200, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t2_no_third", 32'(obf.obf_wr_valid), 32'd0);
    checkOutput("t2_full_after", 32'(collector_full), 32'd0);
    checkOutput("t2_ovf_sticky", 32'(overflow), 32'd1);

    // Ready toggling every cycle during a drain
    setRows(24'h400);
    applyStimulus(1'b1, 1'b0, 1'b0);
    drainCheck("t3", 8, 24, 24'h400, 24'h0, 1'b1);
    checkOutput("t3_idle", 32'(obf.obf_wr_valid), 32'd0);

    // Address wrap: 127 snapshots bring wr_addr to 1016
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("t4_clr_ovf", 32'(overflow), 32'd0);
    for (int s = 0; s < 127; s++) begin
      setRows(output_width'(s * 16));
      applyStimulus(1'b1, 1'b1, 1'b0);
      repeat (9) applyStimulus(1'b0, 1'b1, 1'b0);
    end
    setRows(24'h500);
    applyStimulus(1'b1, 1'b1, 1'b0);
    drainCheck("t4a", 8, 1016, 24'h500, 24'h0, 1'b0);
    setRows(24'h600);
    applyStimulus(1'b1, 1'b1, 1'b0);
    drainCheck("t4b", 8, 0, 24'h600, 24'h0, 1'b0);

    // Capture in the cycle the row-7 beat of a full bank transfers
    setRows(24'h700);
    applyStimulus(1'b1, 1'b0, 1'b0);
    setRows(24'h800);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t5_full", 32'(collector_full), 32'd1);
    checkOutput("t5_valid", 32'(obf.obf_wr_valid), 32'd1);
    setRows(24'h900);
    for (int i = 0; i < nb_pe_row; i++) begin
      checkOutput($sformatf("t5_addr[%0d]", i), 32'(obf.obf_wr_addr), 32'(8 + i));
      checkOutput($sformatf("t5_data[%0d]", i), 32'(obf.obf_wr_data), 32'(24'h700 + i));
      applyStimulus(i == nb_pe_row - 1, 1'b1, 1'b0);
    end
    checkOutput("t5_ovf", 32'(overflow), 32'd0);
    checkOutput("t5_full_after", 32'(collector_full), 32'd1);
    drainCheck("t5", 16, 16, 24'h800, 24'h900, 1'b0);

    // clr mid-drain with overflow set; clr beats a same-cycle capture
    setRows(24'hA00);
    applyStimulus(1'b1, 1'b0, 1'b0);
    setRows(24'hB00);
    applyStimulus(1'b1, 1'b0, 1'b0);
    setRows(24'hC00);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t5c_valid", 32'(obf.obf_wr_valid), 32'd1);
    checkOutput("t5c_addr", 32'(obf.obf_wr_addr), 32'd32);
    checkOutput("t5c_ovf", 32'(overflow), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("clr_valid", 32'(obf.obf_wr_valid), 32'd0);
    checkOutput("clr_addr", 32'(obf.obf_wr_addr), 32'd0);
    checkOutput("clr_ovf", 32'(overflow), 32'd0);
    checkOutput("clr_full", 32'(collector_full), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("clr_prio_valid", 32'(obf.obf_wr_valid), 32'd0);

    // Negative row value
`ifdef OBF_RELU_EN
    relu_exp = '0;
`else
    relu_exp = 24'hFFFFF0;
`endif
    setRows(24'd1);
    rows_bus[0 +: output_width] = 24'hFFFFF0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int j = 0; j < nb_pe_row; j++) begin
      checkOutput($sformatf("t6_addr[%0d]", j), 32'(obf.obf_wr_addr), 32'(j));
      checkOutput($sformatf("t6_data[%0d]", j), 32'(obf.obf_wr_data),
                  (j == 0) ? 32'(relu_exp) : 32'(j + 1));
      applyStimulus(1'b0, 1'b1, 1'b0);
    end
    checkOutput("t6_idle", 32'(obf.obf_wr_valid), 32'd0);

    // Reset asserted mid-drain discards the snapshot
    setRows(24'hD00);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("rmid_valid_before", 32'(obf.obf_wr_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rmid_valid", 32'(obf.obf_wr_valid), 32'd0);
    checkOutput("rmid_addr", 32'(obf.obf_wr_addr), 32'd0);
    checkOutput("rmid_full", 32'(collector_full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("rmid_lost", 32'(obf.obf_wr_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
